// File: rtl/tug_referee.sv
// Tug-of-war referee: arbitrates press pulses, walks the lit LED, scores rounds,
// pauses for a tick-timed hold after each round and ends the match at WIN_SCORE.
module tug_referee #(
    parameter int NUM_LEDS      = 9,
    parameter int CENTER        = 5,
    parameter int WIN_SCORE     = 7,
    parameter int RESTART_TICKS = 4
) (
    input  logic                Clock_i,
    input  logic                Reset_i,
    input  logic                tick_i,
    input  logic                L_i,
    input  logic                R_i,
    output logic [NUM_LEDS-1:0] lights_o,
    output logic [1:0]          winner_o,
    output logic [2:0]          l_score_o,
    output logic [2:0]          r_score_o,
    output logic [6:0]          hex_win_o,
    output logic                game_over_o
);

    localparam int PW = $clog2(NUM_LEDS + 1);
    localparam int CW = $clog2(RESTART_TICKS + 1);

    localparam logic [PW-1:0] POS_CENTER = PW'(CENTER);
    localparam logic [PW-1:0] POS_LEFT   = PW'(NUM_LEDS);
    localparam logic [PW-1:0] POS_RIGHT  = PW'(1);
    localparam logic [CW-1:0] CNT_START  = CW'(RESTART_TICKS);
    localparam logic [CW-1:0] CNT_LAST   = CW'(1);
    localparam logic [2:0]    SCORE_MAX  = 3'(WIN_SCORE);

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_LEFT  = 2'b01;
    localparam logic [1:0] WIN_RIGHT = 2'b10;

    localparam logic [6:0] HEX_BLANK = 7'b1111111;
    localparam logic [6:0] HEX_ONE   = 7'b1111001;
    localparam logic [6:0] HEX_TWO   = 7'b0100100;

    localparam logic [NUM_LEDS-1:0] LIGHT_LSB = NUM_LEDS'(1);

    typedef enum logic [1:0] {
        PLAY,
        HOLD,
        MATCH_OVER
    } state_t;

    state_t                state_q,     state_d;
    logic [PW-1:0]         pos_q,       pos_d;
    logic [CW-1:0]         cnt_q,       cnt_d;
    logic [1:0]            winner_q,    winner_d;
    logic [2:0]            l_score_q,   l_score_d;
    logic [2:0]            r_score_q,   r_score_d;
    logic [6:0]            hex_q,       hex_d;
    logic [NUM_LEDS-1:0]   lights_q,    lights_d;
    logic                  game_over_q, game_over_d;

    logic                  left_press;
    logic                  right_press;
    logic [2:0]            winner_score;

    // Simultaneous presses cancel, so only a lone press counts as a move.
    assign left_press   = L_i & ~R_i;
    assign right_press  = R_i & ~L_i;
    assign winner_score = (winner_q == WIN_LEFT) ? l_score_q : r_score_q;

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        cnt_d     = cnt_q;
        winner_d  = winner_q;
        l_score_d = l_score_q;
        r_score_d = r_score_q;
        hex_d     = hex_q;

        case (state_q)
            PLAY: begin
                if (left_press) begin
                    if (pos_q == POS_LEFT) begin
                        state_d  = HOLD;
                        winner_d = WIN_LEFT;
                        hex_d    = HEX_ONE;
                        cnt_d    = CNT_START;
                        if (l_score_q < SCORE_MAX) begin
                            l_score_d = l_score_q + 3'd1;
                        end
                    end else begin
                        pos_d = pos_q + PW'(1);
                    end
                end else if (right_press) begin
                    if (pos_q == POS_RIGHT) begin
                        state_d  = HOLD;
                        winner_d = WIN_RIGHT;
                        hex_d    = HEX_TWO;
                        cnt_d    = CNT_START;
                        if (r_score_q < SCORE_MAX) begin
                            r_score_d = r_score_q + 3'd1;
                        end
                    end else begin
                        pos_d = pos_q - PW'(1);
                    end
                end
            end

            HOLD: begin
                if (tick_i) begin
                    if (cnt_q == CNT_LAST) begin
                        if (winner_score == SCORE_MAX) begin
                            state_d = MATCH_OVER;
                        end else begin
                            state_d  = PLAY;
                            pos_d    = POS_CENTER;
                            winner_d = WIN_NONE;
                            hex_d    = HEX_BLANK;
                        end
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end

            default: begin
            end
        endcase

        // Outputs are derived from next state so they appear registered alongside it.
        lights_d    = (state_d == PLAY) ? (LIGHT_LSB << (pos_d - PW'(1))) : '0;
        game_over_d = (state_d == MATCH_OVER);
    end

    always_ff @(posedge Clock_i) begin
        if (!Reset_i) begin
            state_q     <= PLAY;
            pos_q       <= POS_CENTER;
            cnt_q       <= '0;
            winner_q    <= WIN_NONE;
            l_score_q   <= '0;
            r_score_q   <= '0;
            hex_q       <= HEX_BLANK;
            lights_q    <= LIGHT_LSB << (POS_CENTER - PW'(1));
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            cnt_q       <= cnt_d;
            winner_q    <= winner_d;
            l_score_q   <= l_score_d;
            r_score_q   <= r_score_d;
            hex_q       <= hex_d;
            lights_q    <= lights_d;
            game_over_q <= game_over_d;
        end
    end

    assign lights_o    = lights_q;
    assign winner_o    = winner_q;
    assign l_score_o   = l_score_q;
    assign r_score_o   = r_score_q;
    assign hex_win_o   = hex_q;
    assign game_over_o = game_over_q;

endmodule

// File: tb/tb_tug_referee.sv
// Self-checking bench for tug_referee: directed vector table, corner-case sequences
// and randomized presses/ticks against a game-rules reference model.
module tb_tug_referee;

    localparam int NUM_LEDS      = 9;
    localparam int CENTER        = 5;
    localparam int WIN_SCORE     = 7;
    localparam int RESTART_TICKS = 4;

    logic          Clock;
    logic          Reset;
    logic          tick;
    logic          L;
    logic          R;
    logic [8:0]    lights;
    logic [1:0]    winner;
    logic [2:0]    l_score;
    logic [2:0]    r_score;
    logic [6:0]    hex_win;
    logic          game_over;

    int checks;
    int errors;

    // Reference model of the game: phase 0 = playing, 1 = paused after a round, 2 = match over.
    int mPhase;
    int mPos;
    int mWinner;
    int mScore [1:2];
    int mPause;

    tug_referee #(
        .NUM_LEDS(NUM_LEDS),
        .CENTER(CENTER),
        .WIN_SCORE(WIN_SCORE),
        .RESTART_TICKS(RESTART_TICKS)
    ) dut (
        .Clock_i(Clock),
        .Reset_i(Reset),
        .tick_i(tick),
        .L_i(L),
        .R_i(R),
        .lights_o(lights),
        .winner_o(winner),
        .l_score_o(l_score),
        .r_score_o(r_score),
        .hex_win_o(hex_win),
        .game_over_o(game_over)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic       rstN;
        logic       tk;
        logic       l;
        logic       r;
        logic [8:0] expLights;
        logic [1:0] expWinner;
        logic [2:0] expL;
        logic [2:0] expR;
        logic [6:0] expHex;
        logic       expOver;
    } vec_t;

    vec_t vecs [15];

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelStep(input logic rstN, input logic tk, input logic l, input logic r);
        int side;
        if (!rstN) begin
            mPhase = 0; mPos = CENTER; mWinner = 0;
            mScore[1] = 0; mScore[2] = 0; mPause = 0;
            return;
        end
        side = (l && !r) ? 1 : ((r && !l) ? 2 : 0);
        if (mPhase == 0 && side != 0) begin
            // Left pushes the light toward NUM_LEDS, right toward 1; stepping off the end wins.
            if ((side == 1 && mPos == NUM_LEDS) || (side == 2 && mPos == 1)) begin
                mPhase  = 1;
                mWinner = side;
                mScore[side] = (mScore[side] + 1 > WIN_SCORE) ? WIN_SCORE : mScore[side] + 1;
                mPause  = RESTART_TICKS;
            end else begin
                mPos = mPos + ((side == 1) ? 1 : -1);
            end
        end else if (mPhase == 1 && tk) begin
            mPause--;
            if (mPause == 0) begin
                if (mScore[mWinner] == WIN_SCORE) begin
                    mPhase = 2;
                end else begin
                    mPhase = 0; mPos = CENTER; mWinner = 0;
                end
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [8:0] eLights;
        logic [6:0] eHex;
        eLights = (mPhase == 0) ? 9'(1 << (mPos - 1)) : 9'd0;
        eHex    = (mWinner == 1) ? 7'b1111001 : ((mWinner == 2) ? 7'b0100100 : 7'b1111111);
        checkVal({tag, ".lights"},    32'(lights),    32'(eLights));
        checkVal({tag, ".winner"},    32'(winner),    32'(mWinner));
        checkVal({tag, ".l_score"},   32'(l_score),   32'(mScore[1]));
        checkVal({tag, ".r_score"},   32'(r_score),   32'(mScore[2]));
        checkVal({tag, ".hex_win"},   32'(hex_win),   32'(eHex));
        checkVal({tag, ".game_over"}, 32'(game_over), 32'(mPhase == 2));
    endtask

    task automatic applyStimulus(input logic rstN, input logic tk, input logic l, input logic r);
        @(negedge Clock);
        Reset = rstN; tick = tk; L = l; R = r;
        @(posedge Clock);
        #1;
        modelStep(rstN, tk, l, r);
        Reset = 1'b1; tick = 1'b0; L = 1'b0; R = 1'b0;
    endtask

    task automatic stepAndCheck(input logic rstN, input logic tk, input logic l, input logic r,
                                input string tag);
        applyStimulus(rstN, tk, l, r);
        checkOutput(tag);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Reset = 1'b0; tick = 1'b0; L = 1'b0; R = 1'b0;
        modelStep(1'b0, 1'b0, 1'b0, 1'b0);

        //            rst  tk    L     R     lights        win    l     r     hex           over
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 9'b000010000, 2'b00, 3'd0, 3'd0, 7'b1111111, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 9'b000100000, 2'b00, 3'd0, 3'd0, 7'b1111111, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 9'b001000000, 2'b00, 3'd0, 3'd0, 7'b1111111, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 9'b010000000, 2'b00, 3'd0, 3'd0, 7'b1111111, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 9'b100000000, 2'b00, 3'd0, 3'd0, 7'b1111111, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 9'b000000000, 2'b01, 3'd1, 3'd0, 7'b1111001, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 9'b000000000, 2'b01, 3'd1, 3'd0, 7'b1111001, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 9'b000000000, 2'b01, 3'd1, 3'd0, 7'b1111001, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 9'b000000000, 2'b01, 3'd1, 3'd0, 7'b1111001, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 9'b000000000, 2'b01, 3'd1, 3'd0, 7'b1111001, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 9'b000010000, 2'b00, 3'd1, 3'd0, 7'b1111111, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 9'b000010000, 2'b00, 3'd1, 3'd0, 7'b1111111, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 9'b000100000, 2'b00, 3'd1, 3'd0, 7'b1111111, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 9'b000010000, 2'b00, 3'd1, 3'd0, 7'b1111111, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 9'b000001000, 2'b00, 3'd1, 3'd0, 7'b1111111, 1'b0};

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].rstN, vecs[i].tk, vecs[i].l, vecs[i].r);
            checkVal($sformatf("vec%0d.lights", i),  32'(lights),    32'(vecs[i].expLights));
            checkVal($sformatf("vec%0d.winner", i),  32'(winner),    32'(vecs[i].expWinner));
            checkVal($sformatf("vec%0d.l_score", i), 32'(l_score),   32'(vecs[i].expL));
            checkVal($sformatf("vec%0d.r_score", i), 32'(r_score),   32'(vecs[i].expR));
            checkVal($sformatf("vec%0d.hex", i),     32'(hex_win),   32'(vecs[i].expHex));
            checkVal($sformatf("vec%0d.over", i),    32'(game_over), 32'(vecs[i].expOver));
        end

        // Presses during the pause with no tick must change nothing.
        stepAndCheck(1'b0, 1'b0, 1'b0, 1'b0, "hold.reset");
        for (int i = 0; i < 5; i++) stepAndCheck(1'b1, 1'b0, 1'b1, 1'b0, "hold.walk");
        for (int i = 0; i < 20; i++) begin
            stepAndCheck(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "hold.idle");
        end
        checkVal("hold.lights_dark", 32'(lights), 32'd0);
        checkVal("hold.l_score", 32'(l_score), 32'd1);

        // Right takes seven rounds and the match locks.
        stepAndCheck(1'b0, 1'b0, 1'b0, 1'b0, "match.reset");
        for (int round = 0; round < WIN_SCORE; round++) begin
            for (int i = 0; i < CENTER; i++) stepAndCheck(1'b1, 1'b0, 1'b0, 1'b1, "match.push");
            for (int i = 0; i < RESTART_TICKS; i++) stepAndCheck(1'b1, 1'b1, 1'b0, 1'b0, "match.tick");
        end
        checkVal("match.r_score", 32'(r_score), 32'd7);
        checkVal("match.game_over", 32'(game_over), 32'd1);
        checkVal("match.hex", 32'(hex_win), 32'(7'b0100100));
        for (int i = 0; i < 10; i++) begin
            stepAndCheck(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), "match.frozen");
        end
        checkVal("match.still_over", 32'(game_over), 32'd1);
        stepAndCheck(1'b0, 1'b1, 1'b1, 1'b0, "match.reset_out");
        checkVal("match.reset_lights", 32'(lights), 32'(9'b000010000));

        // Reset wins over a winning left press at the edge.
        for (int i = 0; i < 4; i++) stepAndCheck(1'b1, 1'b0, 1'b1, 1'b0, "rstwin.walk");
        checkVal("rstwin.at_edge", 32'(lights), 32'(9'b100000000));
        stepAndCheck(1'b0, 1'b0, 1'b1, 1'b0, "rstwin.reset");
        checkVal("rstwin.l_score", 32'(l_score), 32'd0);
        checkVal("rstwin.winner", 32'(winner), 32'd0);

        // Randomized play against the reference model.
        for (int i = 0; i < 3000; i++) begin
            stepAndCheck(1'($urandom_range(0, 199) != 0), 1'($urandom_range(0, 3) == 0),
                         1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) == 0), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
